// File: rtl/instruction_queue_dispatcher.sv
// Instruction queue dispatcher: pops control-unit queue entries, expands each
// entry into copy_count copies and issues up to ISSUE_WIDTH copies per
// handshake, with per-copy cache and main-memory addresses.
module instruction_queue_dispatcher #(
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int ISSUE_WIDTH           = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              queue_empty,
  output logic                              queue_re,
  input  logic [1:0]                        q_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0]    q_copy_count,
  input  logic [8:0]                        q_arith_instr,
  input  logic [2:0]                        q_ram_instr,
  input  logic [6:0]                        q_ld_st_instr,
  input  logic [17:0]                       q_cache_addr,
  input  logic [17:0]                       q_main_mem_addr,
  input  logic [17:0]                       q_d_cache_addr,
  input  logic [17:0]                       q_d_main_mem_addr,
  input  logic                              flush,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [1:0]                        issue_count,
  output logic [1:0]                        issue_instr_type,
  output logic [8:0]                        issue_payload,
  output logic [18*ISSUE_WIDTH-1:0]         issue_cache_addr,
  output logic [18*ISSUE_WIDTH-1:0]         issue_main_mem_addr,
  output logic                              issue_last,
  output logic                              dispatch_error,
  output logic [31:0]                       copies_issued
);

  localparam int CW = LOG_SUPERSCALAR_WIDTH + 1;
  localparam int AW = 18;
  localparam logic [CW-1:0] ISSUE_W_C = CW'(ISSUE_WIDTH);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  remaining;
  logic [1:0]     instr_type;
  logic [8:0]     arith_instr;
  logic [2:0]     ram_instr;
  logic [6:0]     ld_st_instr;
  logic [AW-1:0]  cur_cache_addr, cur_main_mem_addr;
  logic [AW-1:0]  d_cache_addr, d_main_mem_addr;
  logic [AW-1:0]  next_cache_addr, next_main_mem_addr;
  logic [AW-1:0]  cache_acc, mem_acc;
  logic [1:0]     beat_count;
  logic           transfer;
  logic           fetch_bad;

  // Next-state, pop request and issue-bus generation for the current beat.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt           = state;
    queue_re            = 1'b0;
    issue_valid         = 1'b0;
    issue_count         = 2'd0;
    issue_instr_type    = 2'd0;
    issue_payload       = 9'd0;
    issue_cache_addr    = '0;
    issue_main_mem_addr = '0;
    issue_last          = 1'b0;
    transfer            = 1'b0;
    beat_count          = (remaining >= ISSUE_W_C) ? 2'(ISSUE_WIDTH) : 2'(remaining);
    cache_acc           = cur_cache_addr;
    mem_acc             = cur_main_mem_addr;
    next_cache_addr     = cur_cache_addr;
    next_main_mem_addr  = cur_main_mem_addr;
    fetch_bad           = (q_copy_count == '0) || (q_instr_type == 2'd3);

    case (state)
      IDLE: begin
        if (!queue_empty && !flush) begin
          queue_re  = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        state_nxt = (flush || fetch_bad) ? IDLE : ISSUE;
      end
      ISSUE: begin
        issue_valid      = 1'b1;
        issue_count      = beat_count;
        issue_instr_type = instr_type;
        issue_last       = (remaining <= ISSUE_W_C);
        case (instr_type)
          2'd0:    issue_payload = {2'b00, ld_st_instr};
          2'd1:    issue_payload = {6'b000000, ram_instr};
          default: issue_payload = arith_instr;
        endcase
        // Walk the slots adding the delta once per occupied slot; the
        // accumulator after the last occupied slot is the next beat's base.
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
          if (k < int'(beat_count)) begin
            issue_cache_addr[18*k +: 18]    = cache_acc;
            issue_main_mem_addr[18*k +: 18] = mem_acc;
            cache_acc = cache_acc + d_cache_addr;
            mem_acc   = mem_acc + d_main_mem_addr;
          end
        end
        next_cache_addr    = cache_acc;
        next_main_mem_addr = mem_acc;
        transfer           = issue_ready;
        if (flush) begin
          state_nxt = IDLE;
        end else if (transfer && issue_last) begin
          if (!queue_empty) begin
            queue_re  = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (reset) begin
      queue_re = 1'b0;
    end
  end

  // State register, entry capture in FETCH and per-transfer bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state             <= IDLE;
      remaining         <= '0;
      instr_type        <= 2'd0;
      arith_instr       <= 9'd0;
      ram_instr         <= 3'd0;
      ld_st_instr       <= 7'd0;
      cur_cache_addr    <= '0;
      cur_main_mem_addr <= '0;
      d_cache_addr      <= '0;
      d_main_mem_addr   <= '0;
      dispatch_error    <= 1'b0;
      copies_issued     <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        FETCH: begin
          remaining         <= q_copy_count;
          instr_type        <= q_instr_type;
          arith_instr       <= q_arith_instr;
          ram_instr         <= q_ram_instr;
          ld_st_instr       <= q_ld_st_instr;
          cur_cache_addr    <= q_cache_addr;
          cur_main_mem_addr <= q_main_mem_addr;
          d_cache_addr      <= q_d_cache_addr;
          d_main_mem_addr   <= q_d_main_mem_addr;
          if (!flush && fetch_bad) begin
            dispatch_error <= 1'b1;
          end
        end
        ISSUE: begin
          if (transfer) begin
            remaining         <= remaining - CW'(beat_count);
            cur_cache_addr    <= next_cache_addr;
            cur_main_mem_addr <= next_main_mem_addr;
            copies_issued     <= copies_issued + 32'(beat_count);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_queue_dispatcher.sv
// Directed testbench for instruction_queue_dispatcher: the bench plays the
// instruction queue and the consumer, and compares the issue bus against
// hand-computed beats.
module tb_instruction_queue_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic        queue_empty;
  logic        queue_re;
  logic [1:0]  q_instr_type;
  logic [3:0]  q_copy_count;
  logic [8:0]  q_arith_instr;
  logic [2:0]  q_ram_instr;
  logic [6:0]  q_ld_st_instr;
  logic [17:0] q_cache_addr, q_main_mem_addr, q_d_cache_addr, q_d_main_mem_addr;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_count;
  logic [1:0]  issue_instr_type;
  logic [8:0]  issue_payload;
  logic [53:0] issue_cache_addr, issue_main_mem_addr;
  logic        issue_last;
  logic        dispatch_error;
  logic [31:0] copies_issued;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_copies = 32'd0;
  logic [122:0] exp_bus;
  logic [122:0] bus;

  assign bus = {issue_valid, issue_count, issue_last, issue_instr_type, issue_payload,
                issue_cache_addr, issue_main_mem_addr};

  instruction_queue_dispatcher #(.LOG_SUPERSCALAR_WIDTH(3), .ISSUE_WIDTH(3)) dut (
    .clk(clk), .reset(reset), .queue_empty(queue_empty), .queue_re(queue_re),
    .q_instr_type(q_instr_type), .q_copy_count(q_copy_count),
    .q_arith_instr(q_arith_instr), .q_ram_instr(q_ram_instr), .q_ld_st_instr(q_ld_st_instr),
    .q_cache_addr(q_cache_addr), .q_main_mem_addr(q_main_mem_addr),
    .q_d_cache_addr(q_d_cache_addr), .q_d_main_mem_addr(q_d_main_mem_addr),
    .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_count(issue_count), .issue_instr_type(issue_instr_type),
    .issue_payload(issue_payload), .issue_cache_addr(issue_cache_addr),
    .issue_main_mem_addr(issue_main_mem_addr), .issue_last(issue_last),
    .dispatch_error(dispatch_error), .copies_issued(copies_issued)
  );

  always #5 clk = ~clk;

  // Expected issue-bus image: slot 0 in the low bits of each address field.
  function automatic logic [122:0] beat_vec(
    input logic [1:0] cnt, input logic last, input logic [1:0] typ, input logic [8:0] pay,
    input logic [17:0] c0, input logic [17:0] c1, input logic [17:0] c2,
    input logic [17:0] m0, input logic [17:0] m1, input logic [17:0] m2);
    return {1'b1, cnt, last, typ, pay, c2, c1, c0, m2, m1, m0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input logic [1:0] typ, input logic [3:0] cnt, input logic [8:0] ar,
                           input logic [2:0] rm, input logic [6:0] ls,
                           input logic [17:0] ca, input logic [17:0] ma,
                           input logic [17:0] dc, input logic [17:0] dm);
    q_instr_type = typ; q_copy_count = cnt; q_arith_instr = ar; q_ram_instr = rm;
    q_ld_st_instr = ls; q_cache_addr = ca; q_main_mem_addr = ma;
    q_d_cache_addr = dc; q_d_main_mem_addr = dm;
  endtask

  task automatic test_reset();
    reset = 1'b1; queue_empty = 1'b0; flush = 1'b0; issue_ready = 1'b0;
    set_entry(2'd0, 4'd0, 9'd0, 3'd0, 7'd0, 18'd0, 18'd0, 18'd0, 18'd0);
    step(); step();
    #1;
    vectors++;
    if (bus !== '0) begin
      miscompares++; $display("FAIL reset_bus: got %h expected 0", bus);
    end
    vectors++;
    if ({queue_re, dispatch_error} !== 2'b00 || copies_issued !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: got re=%b err=%b copies=%0d expected 0/0/0",
               queue_re, dispatch_error, copies_issued);
    end
    reset = 1'b0; queue_empty = 1'b1;
    step();
  endtask

  task automatic test_single();
    set_entry(2'd0, 4'd5, 9'h0, 3'h0, 7'h5A, 18'd100, 18'd1000, 18'd4, 18'd8);
    issue_ready = 1'b1; queue_empty = 1'b0;
    #1;
    vectors++;
    if (queue_re !== 1'b1) begin
      miscompares++; $display("FAIL single_pop: got queue_re=%b expected 1", queue_re);
    end
    step(); queue_empty = 1'b1;
    step(); #1;
    exp_bus = beat_vec(2'd3, 1'b0, 2'd0, 9'h05A, 18'd100, 18'd104, 18'd108,
                       18'd1000, 18'd1008, 18'd1016);
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL single_beat1: got %h expected %h", bus, exp_bus);
    end
    step(); #1;
    exp_bus = beat_vec(2'd2, 1'b1, 2'd0, 9'h05A, 18'd112, 18'd116, 18'd0,
                       18'd1024, 18'd1032, 18'd0);
    vectors++;
    if (bus !== exp_bus || queue_re !== 1'b0) begin
      miscompares++;
      $display("FAIL single_beat2: got %h re=%b expected %h re=0", bus, queue_re, exp_bus);
    end
    step(); #1;
    exp_copies = exp_copies + 32'd5;
    vectors++;
    if (issue_valid !== 1'b0 || copies_issued !== exp_copies) begin
      miscompares++;
      $display("FAIL single_done: got valid=%b copies=%0d expected 0/%0d",
               issue_valid, copies_issued, exp_copies);
    end
  endtask

  task automatic test_backpressure();
    set_entry(2'd0, 4'd5, 9'h0, 3'h0, 7'h5A, 18'd100, 18'd1000, 18'd4, 18'd8);
    issue_ready = 1'b0; queue_empty = 1'b0;
    step();
    step();
    exp_bus = beat_vec(2'd3, 1'b0, 2'd0, 9'h05A, 18'd100, 18'd104, 18'd108,
                       18'd1000, 18'd1008, 18'd1016);
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++;
      if (bus !== exp_bus || queue_re !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall%0d: got %h re=%b expected %h re=0", i, bus, queue_re, exp_bus);
      end
      step();
    end
    issue_ready = 1'b1; queue_empty = 1'b1;
    #1;
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL bp_release: got %h expected %h", bus, exp_bus);
    end
    step(); #1;
    exp_bus = beat_vec(2'd2, 1'b1, 2'd0, 9'h05A, 18'd112, 18'd116, 18'd0,
                       18'd1024, 18'd1032, 18'd0);
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL bp_beat2: got %h expected %h", bus, exp_bus);
    end
    step(); #1;
    exp_copies = exp_copies + 32'd5;
    vectors++;
    if (copies_issued !== exp_copies) begin
      miscompares++; $display("FAIL bp_copies: got %0d expected %0d", copies_issued, exp_copies);
    end
  endtask

  task automatic test_wrap();
    set_entry(2'd1, 4'd3, 9'h0, 3'b101, 7'h0, 18'h00155, 18'h3FFFE, 18'd0, 18'd1);
    issue_ready = 1'b1; queue_empty = 1'b0;
    step(); queue_empty = 1'b1;
    step(); #1;
    exp_bus = beat_vec(2'd3, 1'b1, 2'd1, 9'h005, 18'h00155, 18'h00155, 18'h00155,
                       18'h3FFFE, 18'h3FFFF, 18'h00000);
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL wrap_beat: got %h expected %h", bus, exp_bus);
    end
    step();
    exp_copies = exp_copies + 32'd3;
  endtask

  task automatic test_illegal();
    vectors++;
    if (dispatch_error !== 1'b0) begin
      miscompares++; $display("FAIL illegal_pre: got err=%b expected 0", dispatch_error);
    end
    set_entry(2'd0, 4'd0, 9'h0, 3'h0, 7'h11, 18'd7, 18'd7, 18'd1, 18'd1);
    issue_ready = 1'b1; queue_empty = 1'b0;
    step(); queue_empty = 1'b1;
    step(); #1;
    vectors++;
    if (issue_valid !== 1'b0 || dispatch_error !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_count0: got valid=%b err=%b expected 0/1", issue_valid, dispatch_error);
    end
    set_entry(2'd3, 4'd2, 9'h0, 3'h0, 7'h11, 18'd7, 18'd7, 18'd1, 18'd1);
    queue_empty = 1'b0;
    step(); queue_empty = 1'b1;
    step(); #1;
    vectors++;
    if (issue_valid !== 1'b0 || dispatch_error !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_type3: got valid=%b err=%b expected 0/1", issue_valid, dispatch_error);
    end
    set_entry(2'd2, 4'd2, 9'h1A5, 3'h0, 7'h0, 18'd10, 18'd20, 18'd1, 18'd2);
    queue_empty = 1'b0;
    step(); queue_empty = 1'b1;
    step(); #1;
    exp_bus = beat_vec(2'd2, 1'b1, 2'd2, 9'h1A5, 18'd10, 18'd11, 18'd0,
                       18'd20, 18'd22, 18'd0);
    vectors++;
    if (bus !== exp_bus || dispatch_error !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_recover: got %h err=%b expected %h err=1", bus, dispatch_error, exp_bus);
    end
    step();
    exp_copies = exp_copies + 32'd2;
  endtask

  task automatic test_back_to_back();
    set_entry(2'd2, 4'd1, 9'h011, 3'h0, 7'h0, 18'd200, 18'd300, 18'd5, 18'd7);
    issue_ready = 1'b1; queue_empty = 1'b0;
    step();
    step();
    set_entry(2'd0, 4'd8, 9'h0, 3'h0, 7'h55, 18'd1000, 18'd50, 18'd2, 18'd10);
    #1;
    exp_bus = beat_vec(2'd1, 1'b1, 2'd2, 9'h011, 18'd200, 18'd0, 18'd0,
                       18'd300, 18'd0, 18'd0);
    vectors++;
    if (bus !== exp_bus || queue_re !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_a: got %h re=%b expected %h re=1", bus, queue_re, exp_bus);
    end
    step(); #1;
    vectors++;
    if (issue_valid !== 1'b0 || queue_re !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_bubble: got valid=%b re=%b expected 0/0", issue_valid, queue_re);
    end
    step(); #1;
    exp_bus = beat_vec(2'd3, 1'b0, 2'd0, 9'h055, 18'd1000, 18'd1002, 18'd1004,
                       18'd50, 18'd60, 18'd70);
    vectors++;
    if (bus !== exp_bus || queue_re !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_b1: got %h re=%b expected %h re=0", bus, queue_re, exp_bus);
    end
    step(); #1;
    exp_bus = beat_vec(2'd3, 1'b0, 2'd0, 9'h055, 18'd1006, 18'd1008, 18'd1010,
                       18'd80, 18'd90, 18'd100);
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL b2b_b2: got %h expected %h", bus, exp_bus);
    end
    step(); queue_empty = 1'b1; #1;
    exp_bus = beat_vec(2'd2, 1'b1, 2'd0, 9'h055, 18'd1012, 18'd1014, 18'd0,
                       18'd110, 18'd120, 18'd0);
    vectors++;
    if (bus !== exp_bus) begin
      miscompares++; $display("FAIL b2b_b3: got %h expected %h", bus, exp_bus);
    end
    step(); #1;
    exp_copies = exp_copies + 32'd9;
    vectors++;
    if (issue_valid !== 1'b0 || copies_issued !== exp_copies) begin
      miscompares++;
      $display("FAIL b2b_done: got valid=%b copies=%0d expected 0/%0d",
               issue_valid, copies_issued, exp_copies);
    end
  endtask

  task automatic test_flush();
    set_entry(2'd0, 4'd8, 9'h0, 3'h0, 7'h55, 18'd1000, 18'd50, 18'd2, 18'd10);
    issue_ready = 1'b1; queue_empty = 1'b0;
    step();
    step();
    step();
    flush = 1'b1; #1;
    exp_bus = beat_vec(2'd3, 1'b0, 2'd0, 9'h055, 18'd1006, 18'd1008, 18'd1010,
                       18'd80, 18'd90, 18'd100);
    vectors++;
    if (bus !== exp_bus || queue_re !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_beat2: got %h re=%b expected %h re=0", bus, queue_re, exp_bus);
    end
    step(); flush = 1'b0; queue_empty = 1'b1; #1;
    exp_copies = exp_copies + 32'd6;
    vectors++;
    if (issue_valid !== 1'b0 || copies_issued !== exp_copies) begin
      miscompares++;
      $display("FAIL flush_after: got valid=%b copies=%0d expected 0/%0d",
               issue_valid, copies_issued, exp_copies);
    end
    step(); #1;
    vectors++;
    if (issue_valid !== 1'b0 || queue_re !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_idle: got valid=%b re=%b expected 0/0", issue_valid, queue_re);
    end
  endtask

  task automatic test_reset_mid();
    set_entry(2'd0, 4'd8, 9'h0, 3'h0, 7'h55, 18'd1000, 18'd50, 18'd2, 18'd10);
    issue_ready = 1'b0; queue_empty = 1'b0;
    step();
    step(); #1;
    vectors++;
    if (issue_valid !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: got valid=%b expected 1", issue_valid);
    end
    reset = 1'b1;
    step(); #1;
    vectors++;
    if (bus !== '0 || queue_re !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_bus: got %h re=%b expected 0/0", bus, queue_re);
    end
    vectors++;
    if (dispatch_error !== 1'b0 || copies_issued !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_mid_state: got err=%b copies=%0d expected 0/0", dispatch_error, copies_issued);
    end
    reset = 1'b0; queue_empty = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_illegal();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_queue_dispatcher.md
Name: instruction_queue_dispatcher

Overview:
- Pops entries from the instruction queue written by the control unit.
- Each entry carries a copy_count of 1..SUPERSCALAR_WIDTH plus base addresses and per-copy address deltas.
- Expands each entry into individual copies, computing per-copy cache and main-memory addresses.
- Issues up to ISSUE_WIDTH copies per cycle, in order, over a single valid/ready bus to the execution units.

Parameters:
- LOG_SUPERSCALAR_WIDTH, 3, width of copy_count is LOG_SUPERSCALAR_WIDTH+1; legal copy_count is 1..2^LOG_SUPERSCALAR_WIDTH.
- ISSUE_WIDTH, 3, maximum copies issued per handshake (legal range 1..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- queue_empty  in  1  instruction queue has no entries
- queue_re  out  1  pop request; entry fields valid the following cycle
- q_instr_type  in  2  0=load/store, 1=ram, 2=arith, 3=loop (illegal here)
- q_copy_count  in  LOG_SUPERSCALAR_WIDTH+1  number of copies
- q_arith_instr  in  9  arithmetic payload
- q_ram_instr  in  3  {is_write, cache_slot}
- q_ld_st_instr  in  7  {is_load, cache_slot, regfile_reg, zero_flag, skip_flag}
- q_cache_addr, q_main_mem_addr  in  18 each  base addresses of copy 0
- q_d_cache_addr, q_d_main_mem_addr  in  18 each  per-copy address delta
- flush  in  1  abandon the held entry
- issue_valid  out  1  issue bus holds copies
- issue_ready  in  1  consumer accepts
- issue_count  out  2  copies on the bus, 1..ISSUE_WIDTH
- issue_instr_type  out  2  type of the copies
- issue_payload  out  9  arith_instr, zero-extended ram_instr, or zero-extended ld_st_instr, selected by type
- issue_cache_addr  out  18*ISSUE_WIDTH  slot k at bits [18k +: 18]
- issue_main_mem_addr  out  18*ISSUE_WIDTH  slot k at bits [18k +: 18]
- issue_last  out  1  the bus carries the final copies of the entry
- dispatch_error  out  1  sticky flag for an illegal entry
- copies_issued  out  32  running count of accepted copies

Behaviour:
- States: IDLE, FETCH, ISSUE.
- IDLE:
  - queue_re = !queue_empty (combinational, this state only).
  - If queue_re, go to FETCH.
- FETCH:
  - Latch all q_* fields; remaining <= q_copy_count.
  - If q_copy_count == 0 or q_instr_type == 3: set dispatch_error, drop the entry, go to IDLE.
  - Otherwise go to ISSUE.
- ISSUE:
  - issue_valid = 1.
  - issue_count = min(remaining, ISSUE_WIDTH).
  - Slot k address = cur_cache_addr + k*d_cache_addr, mod 2^18; main-memory address likewise.
  - Slots k >= issue_count are driven to 0.
  - issue_last = (remaining <= ISSUE_WIDTH).
- Handshake:
  - A transfer occurs when issue_valid && issue_ready.
  - On a transfer: remaining -= issue_count; cur_addr += issue_count*d_addr (mod 2^18); copies_issued += issue_count.
  - Without a transfer, all issue_* outputs stay stable.
- On a transfer with issue_last:
  - If !queue_empty, assert queue_re in the same cycle and go to FETCH (back-to-back entries, one bubble).
  - Otherwise go to IDLE.
- Delta arithmetic: deltas are unsigned 18-bit and address wrap-around is silent. A delta of 0 yields identical addresses in every slot.
- Ordering: every copy of entry N is issued before any copy of entry N+1. Copies within an entry issue in increasing index order.
- flush:
  - Any state goes to IDLE next cycle; issue_valid is 0 that next cycle.
  - A transfer in the same cycle as flush still counts.
  - A pop already made in IDLE is discarded: FETCH with flush drops the entry.
  - queue_re is not asserted in a flush cycle.
- Reset (any time, including mid-entry): state = IDLE, remaining = 0, all issue_* = 0, queue_re = 0, dispatch_error = 0, copies_issued = 0. Only the reset clears dispatch_error.
- copies_issued wraps at 2^32.

Test Plan:
- Single ld/st entry: copy_count=5, cache_addr=100, d_cache=4, ready=1 -> two beats:
  - Beat 1: count 3, addrs 100/104/108, last=0.
  - Beat 2: count 2, addrs 112/116, last=1.
  - copies_issued=5.
- Back-pressure: same entry with issue_ready=0 for 4 cycles after valid -> outputs stable; no queue_re while the first beat is pending.
- Wrap-around: ram entry, main_mem_addr=0x3FFFE, d_main=1, copy_count=3 -> main-memory slots 0x3FFFE, 0x3FFFF, 0x00000.
- Illegal entries: copy_count=0, then instr_type=3 -> no issue_valid, dispatch_error=1 and held; the following legal arith entry issues normally.
- Back-to-back entries:
  - Entry A: count 1. Entry B: count 8. Queue non-empty throughout.
  - Required: queue_re on A's last transfer; B issues as beats of 3/3/2; no interleaving.
- Mid-entry events:
  - Flush during B's second beat -> IDLE next cycle, remaining copies dropped.
  - Reset during ISSUE -> all outputs 0 next cycle.
